// File: rtl/controlador_de_espera_if.sv
// rtl/controlador_de_espera_if.sv - decode strobes in, stall/commit controls out, for the stall sequencer
interface controlador_de_espera_if;
    logic       isHalt;
    logic       isInsert;
    logic       isDisk;
    logic       diskWrite;
    logic       confirm;
    logic       disk_ack;
    logic       pc_en;
    logic       commit_en;
    logic       disk_req;
    logic       disk_we;
    logic       halted;
    logic       disk_err;
    logic [2:0] state;

    modport master (
        output isHalt, isInsert, isDisk, diskWrite, confirm, disk_ack,
        input  pc_en, commit_en, disk_req, disk_we, halted, disk_err, state
    );

    modport slave (
        input  isHalt, isInsert, isDisk, diskWrite, confirm, disk_ack,
        output pc_en, commit_en, disk_req, disk_we, halted, disk_err, state
    );
endinterface

// File: rtl/controlador_de_espera.sv
// rtl/controlador_de_espera.sv - multi-cycle stall sequencer for the iZero CPU
// Optional disk timeout enabled by defining ESPERA_TIMEOUT_EN.
module controlador_de_espera #(
    parameter int DISK_TIMEOUT = 1024,
    parameter int TO_W         = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    controlador_de_espera_if.slave  bus
);
    typedef enum logic [2:0] {
        RUN       = 3'd0,
        WAIT_IN   = 3'd1,
        DISK_REQ  = 3'd2,
        DISK_WAIT = 3'd3,
        COMMIT    = 3'd4,
        HALTED    = 3'd5
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic confirm_q;
    logic disk_req_q;
    logic disk_we_q;
    logic disk_op;
    logic start;
    logic confirm_rise;
    logic expire;
    logic commit_ok;
    logic disk_start;

    generate
        if ((64'd1 << TO_W) < 64'(DISK_TIMEOUT)) begin : g_bad_cfg
            $error("TO_W too narrow for DISK_TIMEOUT");
        end
    endgenerate

    assign disk_op      = bus.isDisk | bus.diskWrite;
    assign start        = bus.isHalt | bus.isInsert | disk_op;
    assign confirm_rise = bus.confirm & ~confirm_q;
    assign disk_start   = (cur_state == RUN) && (nxt_state == DISK_REQ);

`ifdef ESPERA_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            timed_out_q;
    logic            disk_err_q;

    // An ack on the expiry cycle wins, so expiry is qualified by !disk_ack.
    assign expire    = (cur_state == DISK_WAIT) && !bus.disk_ack &&
                       (to_cnt == TO_W'(DISK_TIMEOUT - 1));
    assign commit_ok = ~timed_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            timed_out_q <= 1'b0;
            disk_err_q  <= 1'b0;
        end else begin
            if (disk_start)
                to_cnt <= '0;
            else if (cur_state == DISK_WAIT)
                to_cnt <= to_cnt + 1'b1;
            timed_out_q <= expire;
            if (expire)
                disk_err_q <= 1'b1;
        end
    end

    assign bus.disk_err = disk_err_q;
`else
    assign expire       = 1'b0;
    assign commit_ok    = 1'b1;
    assign bus.disk_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            cur_state <= RUN;
        else
            cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            RUN: begin
                if (bus.isHalt)
                    nxt_state = HALTED;
                else if (bus.isInsert)
                    nxt_state = WAIT_IN;
                else if (disk_op)
                    nxt_state = DISK_REQ;
            end
            WAIT_IN:   if (confirm_rise) nxt_state = COMMIT;
            DISK_REQ:  nxt_state = bus.disk_ack ? COMMIT : DISK_WAIT;
            DISK_WAIT: if (bus.disk_ack || expire) nxt_state = COMMIT;
            COMMIT:    nxt_state = RUN;
            HALTED:    nxt_state = HALTED;
            default:   nxt_state = RUN;
        endcase
    end

    always_comb begin
        bus.pc_en     = 1'b0;
        bus.commit_en = 1'b0;
        case (cur_state)
            RUN: begin
                bus.pc_en     = ~start;
                bus.commit_en = ~start;
            end
            COMMIT: begin
                bus.pc_en     = 1'b1;
                bus.commit_en = commit_ok;
            end
            default: begin
                bus.pc_en     = 1'b0;
                bus.commit_en = 1'b0;
            end
        endcase
    end

    // Confirm register resets high so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            confirm_q  <= 1'b1;
            disk_req_q <= 1'b0;
            disk_we_q  <= 1'b0;
        end else begin
            confirm_q  <= bus.confirm;
            disk_req_q <= (nxt_state == DISK_REQ) || (nxt_state == DISK_WAIT);
            if (disk_start)
                disk_we_q <= bus.diskWrite;
        end
    end

    assign bus.disk_req = disk_req_q;
    assign bus.disk_we  = disk_we_q;
    assign bus.halted   = (cur_state == HALTED);
    assign bus.state    = cur_state;
endmodule
